fir_error_monitor: RTL and testbench

//  Consumer end of the FIR output stream. Sits beside the approximate-adder FIR and its exact twin.

---
 rtl/fir_error_monitor.sv | 118 +++++++++++
 tb/tb_fir_error_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_error_monitor.sv
// Error statistics between the approximate and exact FIR outputs: skips the fill samples,
// then accumulates sum, max and nonzero count of |y_exact - y_approx| over a fixed window.
//
// state  | meaning
// IDLE   | waiting for start, stats zero after reset
// SKIP   | discarding the FIR delay-line fill pairs
// RUN    | measuring window pairs
// DONE   | window complete, results held until next start
module fir_error_monitor #(
  parameter int N_SAMPLES = 1024,
  parameter int SKIP      = 9,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             valid,
  input  logic [15:0]      y_approx,
  input  logic [15:0]      y_exact,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [16:0]      max_abs_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic             sat
);

  localparam int SKW = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
  localparam int SW  = ACC_W + 1;
  localparam logic [SKW-1:0]   SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [CNT_W-1:0] N_LAST    = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SKW-1:0] skip_cnt;
  logic           clear;
  logic           accept;
  logic [16:0]    err;
  logic [16:0]    abs_err;
  logic [SW-1:0]  sum_ext;

  // 17-bit difference of two sign-extended 16-bit values cannot overflow
  assign err     = {y_exact[15], y_exact} - {y_approx[15], y_approx};
  assign abs_err = err[16] ? (~err + 17'd1) : err;
  assign sum_ext = {1'b0, sum_abs_err} + SW'(abs_err);

  assign busy = (state == S_SKIP) || (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = (SKIP > 0) ? S_SKIP : S_RUN;
        end
      end
      S_SKIP: begin
        if (valid && (skip_cnt == SKIP_LAST)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (valid) begin
          accept = 1'b1;
          if (sample_count == N_LAST) state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      skip_cnt     <= '0;
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      err_count    <= '0;
      sample_count <= '0;
      sat          <= 1'b0;
    end else if (clear) begin
      skip_cnt     <= '0;
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      err_count    <= '0;
      sample_count <= '0;
      sat          <= 1'b0;
    end else if ((state == S_SKIP) && valid) begin
      skip_cnt <= skip_cnt + SKW'(1);
    end else if (accept) begin
      if (sum_ext[ACC_W]) begin
        sum_abs_err <= '1;
        sat         <= 1'b1;
      end else begin
        sum_abs_err <= sum_ext[ACC_W-1:0];
      end
      if (abs_err > max_abs_err) max_abs_err <= abs_err;
      if (abs_err != 17'd0) err_count <= err_count + CNT_W'(1);
      sample_count <= sample_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fir_error_monitor.sv
// Bench for fir_error_monitor: default instance plus a small saturating instance
// (N_SAMPLES=4, SKIP=0, ACC_W=17), both checked every cycle against a behavioural model.
module tb_fir_error_monitor;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start, valid, start1, valid1;
  logic [15:0] y_approx, y_exact, y_approx1, y_exact1;

  logic        busy0, done0, sat0;
  logic [31:0] sum0;
  logic [16:0] max0;
  logic [15:0] errs0, samples0;

  logic        busy1, done1, sat1;
  logic [16:0] sum1;
  logic [16:0] max1;
  logic [3:0]  errs1, samples1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fir_error_monitor dut (
    .clk(clk), .rstN(rstN), .start(start), .valid(valid),
    .y_approx(y_approx), .y_exact(y_exact),
    .busy(busy0), .done(done0), .sum_abs_err(sum0), .max_abs_err(max0),
    .err_count(errs0), .sample_count(samples0), .sat(sat0)
  );

  fir_error_monitor #(.N_SAMPLES(4), .SKIP(0), .ACC_W(17), .CNT_W(4)) dut_small (
    .clk(clk), .rstN(rstN), .start(start1), .valid(valid1),
    .y_approx(y_approx1), .y_exact(y_exact1),
    .busy(busy1), .done(done1), .sum_abs_err(sum1), .max_abs_err(max1),
    .err_count(errs1), .sample_count(samples1), .sat(sat1)
  );

  typedef struct {
    bit     running;
    bit     finished;
    int     seen;
    longint sum;
    int     maxe;
    int     errs;
    int     samples;
    bit     sat;
  } model_t;

  model_t m0 = '{default: 0};
  model_t m1 = '{default: 0};

  // One clock of the run as described at sample-pair level
  function automatic model_t step(model_t m, bit st, bit v, logic signed [15:0] ya,
                                  logic signed [15:0] ye, int n, int skip, int accw);
    model_t r;
    int     ae;
    longint lim;
    r   = m;
    ae  = int'(ye) - int'(ya);
    if (ae < 0) ae = -ae;
    lim = (longint'(1) << accw) - 1;
    if (!r.running) begin
      if (st) begin
        r = '{default: 0};
        r.running = 1'b1;
      end
    end else if (v) begin
      if (r.seen < skip) begin
        r.seen++;
      end else begin
        r.sum += ae;
        if (r.sum > lim) begin
          r.sum = lim;
          r.sat = 1'b1;
        end
        if (ae > r.maxe) r.maxe = ae;
        if (ae != 0) r.errs++;
        r.samples++;
        if (r.samples == n) begin
          r.running  = 1'b0;
          r.finished = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m0 = '{default: 0};
      m1 = '{default: 0};
    end else begin
      m0 = step(m0, start, valid, y_approx, y_exact, 1024, 9, 32);
      m1 = step(m1, start1, valid1, y_approx1, y_exact1, 4, 0, 17);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    else passed++;
  endtask

  always @(negedge clk) begin
    chk("busy0",    longint'(busy0),    longint'(m0.running));
    chk("done0",    longint'(done0),    longint'(m0.finished));
    chk("sum0",     longint'(sum0),     m0.sum);
    chk("max0",     longint'(max0),     longint'(m0.maxe));
    chk("errs0",    longint'(errs0),    longint'(m0.errs));
    chk("samples0", longint'(samples0), longint'(m0.samples));
    chk("sat0",     longint'(sat0),     longint'(m0.sat));
    chk("busy1",    longint'(busy1),    longint'(m1.running));
    chk("done1",    longint'(done1),    longint'(m1.finished));
    chk("sum1",     longint'(sum1),     m1.sum);
    chk("max1",     longint'(max1),     longint'(m1.maxe));
    chk("errs1",    longint'(errs1),    longint'(m1.errs));
    chk("samples1", longint'(samples1), longint'(m1.samples));
    chk("sat1",     longint'(sat1),     longint'(m1.sat));
  end

  // Called at a falling edge; inputs are held through the next rising edge
  task automatic drive(input bit s, input bit v, input logic [15:0] a, input logic [15:0] e);
    start = s; valid = v; y_approx = a; y_exact = e;
    @(negedge clk);
  endtask

  task automatic drive1(input bit s, input bit v, input logic [15:0] a, input logic [15:0] e);
    start1 = s; valid1 = v; y_approx1 = a; y_exact1 = e;
    @(negedge clk);
  endtask

  function automatic logic [15:0] base(int i);
    return 16'(((i % 1000) * 13) - 6000);
  endfunction

  task automatic check_final(input string tag, input longint s, input longint mx,
                             input longint ec, input longint sc);
    chk({tag, "_done"},    longint'(done0),    1);
    chk({tag, "_sum"},     longint'(sum0),     s);
    chk({tag, "_max"},     longint'(max0),     mx);
    chk({tag, "_errs"},    longint'(errs0),    ec);
    chk({tag, "_samples"}, longint'(samples0), sc);
  endtask

  initial begin
    start = 0; valid = 0; y_approx = 0; y_exact = 0;
    start1 = 0; valid1 = 0; y_approx1 = 0; y_exact1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_sum",  longint'(sum0),  0);
    #3 rstN = 1'b1;
    @(negedge clk);

    // 1: exact match; start with valid in the same cycle does not count that pair
    drive(1, 1, 16'd7, 16'd9);
    for (int i = 0; i < 9 + 1024; i++) drive(0, 1, base(i), base(i));
    drive(0, 0, 0, 0);
    check_final("t1", 0, 0, 0, 1024);
    for (int i = 0; i < 3; i++) drive(0, 1, 16'd5, 16'd0);
    chk("t1_done_hold", longint'(samples0), 1024);

    // 2: fill pairs with e=100 are skipped, window e=-3
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, base(i), base(i) + 16'd100);
    for (int i = 0; i < 1024; i++) drive(0, 1, base(i), base(i) - 16'd3);
    check_final("t2", 3072, 3, 1024, 1024);
    chk("t2_model_sum", m0.sum, 3072);

    // 3: extreme differences saturate a 17-bit accumulator
    drive1(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive1(0, 1, 16'h8000, 16'h7FFF);
    drive1(0, 0, 0, 0);
    chk("t3_max",  longint'(max1),  65535);
    chk("t3_sat",  longint'(sat1),  1);
    chk("t3_sum",  longint'(sum1),  131071);
    chk("t3_done", longint'(done1), 1);
    chk("t3_model_sum", m1.sum, 131071);

    // 4: valid every other cycle, start pulsed mid-run is ignored
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9 + 1024; i++) begin
      if (i < 9) drive(0, 1, base(i), base(i) + 16'd100);
      else drive(i == 500, 1, base(i), base(i) - 16'd3);
      drive(0, 0, 16'd1, 16'd900);
    end
    check_final("t4", 3072, 3, 1024, 1024);

    // 6: restart from DONE clears previous stats
    drive(1, 0, 0, 0);
    chk("t6_cleared", longint'(sum0), 0);
    for (int i = 0; i < 9; i++) drive(0, 1, base(i), base(i) + 16'd50);
    for (int i = 0; i < 1024; i++) drive(0, 1, base(i), base(i) + 16'd1);
    check_final("t6", 1024, 1, 1024, 1024);

    // 5: reset mid-run aborts, then a normal run with e alternating 0 and 2
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9 + 500; i++) drive(0, 1, base(i), base(i) + 16'd4);
    chk("t5_mid_samples", longint'(samples0), 500);
    #3 rstN = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy",    longint'(busy0),    0);
    chk("t5_rst_sum",     longint'(sum0),     0);
    chk("t5_rst_max",     longint'(max0),     0);
    chk("t5_rst_samples", longint'(samples0), 0);
    #3 rstN = 1'b1;
    @(negedge clk);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, base(i), base(i) + 16'd77);
    for (int i = 0; i < 1024; i++) drive(0, 1, base(i), base(i) + ((i % 2 == 1) ? 16'd2 : 16'd0));
    check_final("t5", 1024, 2, 512, 1024);
    chk("t5_sat", longint'(sat0), 0);

    drive(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
